// File: rtl/cpu_tgen.sv
`default_nettype none
// ============================================================================
// Module   : cpu_tgen
// Purpose  : CPU T-state clock with programmable divisor, wait-state stretch,
//            multi-row frame INT generator and per-frame T-state counter.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_tgen #(
    parameter int DIV_W  = 3,
    parameter int N_INT  = 3,
    parameter int LEN_W  = 6,
    parameter int WAIT_W = 3,
    parameter int TS_W   = 17
) (
    input  logic                 clk28,
    input  logic                 rst_n,
    input  logic [8:0]           hc,
    input  logic [8:0]           vc,
    input  logic [DIV_W-1:0]     div,
    input  logic                 stall,
    input  logic                 wait_req,
    input  logic [WAIT_W-1:0]    wait_cycles,
    input  logic [N_INT*9-1:0]   int_v,
    input  logic [8:0]           int_h,
    input  logic [N_INT-1:0]     int_en,
    input  logic [LEN_W-1:0]     int_len,
    output logic                 clkcpu,
    output logic                 clkcpu_ck,
    output logic                 clkcpu_fall,
    output logic                 n_int_next,
    output logic                 n_int,
    output logic                 waiting,
    output logic [TS_W-1:0]      tstate
);

    localparam int c_DUR_W = DIV_W + 1;

    logic [DIV_W-1:0]   r_phase;
    logic [DIV_W-1:0]   r_div;
    logic               r_clk_d;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [c_DUR_W-1:0] r_dur;
    logic [LEN_W-1:0]   r_int_cnt;

    logic [DIV_W-1:0]   w_div_eff;
    logic [DIV_W-1:0]   w_phase_last;
    logic [c_DUR_W-1:0] w_dur_last;
    logic               w_wait_load;
    logic               w_wait_dec;
    logic               w_run;
    logic               w_toggle;
    logic [N_INT-1:0]   w_match;
    logic               w_begin;
    logic               w_int_accept;
    logic               w_int_step;

    assign w_div_eff    = (div == '0) ? DIV_W'(1) : div;
    assign w_phase_last = r_div - DIV_W'(1);
    assign w_dur_last   = {r_div, 1'b0} - c_DUR_W'(1);

    assign w_wait_load = clkcpu_ck && wait_req && (wait_cycles != '0)
                         && !stall && (r_wait_cnt == '0);
    assign w_wait_dec  = !stall && (r_wait_cnt != '0) && (r_dur == w_dur_last);

    // The divider may toggle on the very edge the last wait T-state expires,
    // so the stretch adds exactly wait_cycles full periods to the high phase.
    assign w_run    = !stall && !w_wait_load
                      && ((r_wait_cnt == '0) || (w_wait_dec && (r_wait_cnt == WAIT_W'(1))));
    assign w_toggle = w_run && (r_phase == w_phase_last);

    genvar gi;
    generate
        for (gi = 0; gi < N_INT; gi++) begin : g_int_match
            assign w_match[gi] = int_en[gi] && (vc == int_v[9*gi +: 9]) && (hc == int_h);
        end
    endgenerate

    assign w_begin      = |w_match;
    assign w_int_accept = w_begin && (r_int_cnt == '0);
    assign w_int_step   = w_int_accept || (clkcpu_ck && (r_int_cnt != '0));

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            clkcpu      <= 1'b0;
            clkcpu_ck   <= 1'b0;
            clkcpu_fall <= 1'b0;
            r_phase     <= '0;
            r_div       <= w_div_eff;
            r_clk_d     <= 1'b0;
            r_wait_cnt  <= '0;
            r_dur       <= '0;
            waiting     <= 1'b0;
            r_int_cnt   <= '0;
            n_int_next  <= 1'b1;
            n_int       <= 1'b1;
            tstate      <= '0;
        end else begin
            if (w_toggle) begin
                clkcpu  <= ~clkcpu;
                r_phase <= '0;
                r_div   <= w_div_eff;
            end else if (w_run) begin
                r_phase <= r_phase + DIV_W'(1);
            end

            // Edge history freezes with the clock so a strobe is deferred, not lost.
            if (!stall) begin
                r_clk_d <= clkcpu;
            end
            clkcpu_ck   <= !stall && clkcpu && !r_clk_d;
            clkcpu_fall <= !stall && !clkcpu && r_clk_d;

            if (w_wait_load) begin
                r_wait_cnt <= wait_cycles;
                r_dur      <= '0;
                waiting    <= 1'b1;
            end else if (!stall && (r_wait_cnt != '0)) begin
                if (w_wait_dec) begin
                    r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    r_dur      <= '0;
                    if (r_wait_cnt == WAIT_W'(1)) begin
                        waiting <= 1'b0;
                    end
                end else begin
                    r_dur <= r_dur + c_DUR_W'(1);
                end
            end

            if (w_int_step) begin
                r_int_cnt  <= r_int_cnt + LEN_W'(1);
                n_int_next <= (r_int_cnt < int_len) ? 1'b0 : 1'b1;
            end

            if (clkcpu_ck) begin
                n_int <= n_int_next;
                if (!n_int_next && n_int) begin
                    tstate <= '0;
                end else if (tstate != '1) begin
                    tstate <= tstate + TS_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_tgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_tgen
// Purpose  : Directed, table-driven self-checking bench for cpu_tgen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_tgen;

    localparam int c_DIV_W  = 3;
    localparam int c_N_INT  = 3;
    localparam int c_LEN_W  = 6;
    localparam int c_WAIT_W = 3;
    localparam int c_TS_W   = 17;
    localparam logic [8:0] c_IDLE = 9'd300;

    logic                    clk28 = 1'b0;
    logic                    rst_n;
    logic [8:0]              hc;
    logic [8:0]              vc;
    logic [c_DIV_W-1:0]      div;
    logic                    stall;
    logic                    wait_req;
    logic [c_WAIT_W-1:0]     wait_cycles;
    logic [c_N_INT*9-1:0]    int_v;
    logic [8:0]              int_h;
    logic [c_N_INT-1:0]      int_en;
    logic [c_LEN_W-1:0]      int_len;
    logic                    clkcpu;
    logic                    clkcpu_ck;
    logic                    clkcpu_fall;
    logic                    n_int_next;
    logic                    n_int;
    logic                    waiting;
    logic [c_TS_W-1:0]       tstate;

    cpu_tgen #(
        .DIV_W (c_DIV_W),
        .N_INT (c_N_INT),
        .LEN_W (c_LEN_W),
        .WAIT_W(c_WAIT_W),
        .TS_W  (c_TS_W)
    ) u_dut (
        .clk28      (clk28),
        .rst_n      (rst_n),
        .hc         (hc),
        .vc         (vc),
        .div        (div),
        .stall      (stall),
        .wait_req   (wait_req),
        .wait_cycles(wait_cycles),
        .int_v      (int_v),
        .int_h      (int_h),
        .int_en     (int_en),
        .int_len    (int_len),
        .clkcpu     (clkcpu),
        .clkcpu_ck  (clkcpu_ck),
        .clkcpu_fall(clkcpu_fall),
        .n_int_next (n_int_next),
        .n_int      (n_int),
        .waiting    (waiting),
        .tstate     (tstate)
    );

    always #5 clk28 = ~clk28;

    typedef struct {
        logic [c_DIV_W-1:0] div;
        int                 exp_period;
        int                 exp_high;
    } per_vec_t;

    typedef struct {
        logic [26:0]        v;
        logic [2:0]         en;
        logic [5:0]         len;
        logic [8:0]         row;
        int                 exp_low;
    } int_vec_t;

    per_vec_t pv[5];
    int_vec_t iv[8];

    int n_pass  = 0;
    int n_total = 0;

    int r_fall_seen;
    int r_ts_first;
    int r_low_cks;
    int r_ts_end;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic wait_ck(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk28);
            cyc++;
        end while (!clkcpu_ck && cyc < 200);
    endtask

    // From a clkcpu_ck cycle, counts clk28 cycles until the fall strobe.
    task automatic measure_high(output int cyc, output int wc, output int cc);
        cyc = 0; wc = 0; cc = 0;
        do begin
            @(negedge clk28);
            wait_req = 1'b0;
            cyc++;
            if (waiting) wc++;
            if (clkcpu_ck) cc++;
        end while (!clkcpu_fall && cyc < 200);
    endtask

    task automatic trigger(input logic [8:0] row);
        @(negedge clk28);
        vc = row;
        hc = 9'd4;
        @(negedge clk28);
        vc = c_IDLE;
        hc = c_IDLE;
    endtask

    task automatic measure_int();
        int g;
        g = 0;
        r_fall_seen = 0; r_ts_first = -1; r_low_cks = 0; r_ts_end = -1;
        while (n_int && g < 100) begin
            @(negedge clk28);
            g++;
        end
        if (!n_int) begin
            r_fall_seen = 1;
            r_ts_first  = int'(tstate);
            g = 0;
            do begin
                if (clkcpu_ck) r_low_cks++;
                @(negedge clk28);
                g++;
            end while (!n_int && g < 2000);
            r_ts_end = int'(tstate);
        end
    endtask

    initial begin
        int p, h, wc, cc, a, b, hi;

        pv[0] = '{3'd4, 8, 4};
        pv[1] = '{3'd2, 4, 2};
        pv[2] = '{3'd1, 2, 1};
        pv[3] = '{3'd0, 2, 1};
        pv[4] = '{3'd3, 6, 3};

        iv[0] = '{{9'd0,   9'd0,   9'd248}, 3'b001, 6'd36, 9'd248, 36};
        iv[1] = '{{9'd212, 9'd106, 9'd0},   3'b111, 6'd32, 9'd0,   32};
        iv[2] = '{{9'd212, 9'd106, 9'd0},   3'b111, 6'd32, 9'd106, 32};
        iv[3] = '{{9'd212, 9'd106, 9'd0},   3'b111, 6'd32, 9'd212, 32};
        iv[4] = '{{9'd212, 9'd106, 9'd0},   3'b101, 6'd32, 9'd106, 0};
        iv[5] = '{{9'd212, 9'd106, 9'd0},   3'b111, 6'd0,  9'd0,   0};
        iv[6] = '{{9'd212, 9'd106, 9'd0},   3'b100, 6'd5,  9'd212, 5};
        iv[7] = '{{9'd212, 9'd106, 9'd0},   3'b010, 6'd5,  9'd212, 0};

        rst_n = 1'b0; hc = c_IDLE; vc = c_IDLE; div = 3'd4; stall = 1'b0;
        wait_req = 1'b0; wait_cycles = '0; int_v = '0; int_h = 9'd4;
        int_en = '0; int_len = 6'd36;
        repeat (3) @(negedge clk28);
        check("rst_clkcpu", int'(clkcpu), 0);
        check("rst_ck", int'(clkcpu_ck), 0);
        check("rst_fall", int'(clkcpu_fall), 0);
        check("rst_n_int", int'(n_int), 1);
        check("rst_n_int_next", int'(n_int_next), 1);
        check("rst_waiting", int'(waiting), 0);
        check("rst_tstate", int'(tstate), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            div = pv[i].div;
            repeat (3) wait_ck(p);
            wait_ck(p);
            check($sformatf("period_div%0d", pv[i].div), p, pv[i].exp_period);
            measure_high(h, wc, cc);
            check($sformatf("high_div%0d", pv[i].div), h, pv[i].exp_high);
            check($sformatf("ck_width_div%0d", pv[i].div), cc, 0);
        end

        // div change mid-run: old phase completes, then 2-cycle period.
        div = 3'd4;
        repeat (3) wait_ck(p);
        div = 3'd1;
        wait_ck(a);
        wait_ck(b);
        check("switch_first", a, 5);
        check("switch_second", b, 2);

        // Wait states at div=2.
        div = 3'd2;
        repeat (3) wait_ck(p);
        wait_req = 1'b1; wait_cycles = 3'd2;
        measure_high(h, wc, cc);
        check("wait_high", h, 10);
        check("wait_waiting", wc, 8);
        check("wait_no_ck", cc, 0);

        wait_ck(p);
        wait_req = 1'b1; wait_cycles = 3'd0;
        measure_high(h, wc, cc);
        check("wait0_high", h, 2);
        check("wait0_waiting", wc, 0);

        // Request outside clkcpu_ck is ignored.
        wait_ck(p);
        measure_high(h, wc, cc);
        wait_req = 1'b1; wait_cycles = 3'd3;
        @(negedge clk28);
        wait_req = 1'b0;
        wait_ck(p);
        measure_high(h, wc, cc);
        check("wait_off_ck_high", h, 2);
        check("wait_off_ck_waiting", wc, 0);

        // Stall for 5 cycles right after a rising edge at div=4.
        div = 3'd4;
        repeat (3) wait_ck(p);
        stall = 1'b1;
        a = 0; hi = 0;
        repeat (5) begin
            @(negedge clk28);
            a++;
            if (clkcpu && !clkcpu_ck && !clkcpu_fall) hi++;
        end
        stall = 1'b0;
        do begin
            @(negedge clk28);
            a++;
        end while (!clkcpu_ck && a < 200);
        check("stall_held_high", hi, 5);
        check("stall_period", a, 13);

        for (int i = 0; i < 8; i++) begin
            int_v = iv[i].v; int_en = iv[i].en; int_len = iv[i].len;
            trigger(iv[i].row);
            measure_int();
            check($sformatf("int%0d_low_cks", i), r_low_cks, iv[i].exp_low);
            if (iv[i].exp_low != 0) begin
                check($sformatf("int%0d_ts_first", i), r_ts_first, 0);
                check($sformatf("int%0d_ts_end", i), r_ts_end, iv[i].exp_low);
            end
            repeat (70) wait_ck(p);
        end

        // Reset in the middle of an INT pulse.
        int_v = iv[0].v; int_en = iv[0].en; int_len = iv[0].len;
        trigger(9'd248);
        a = 0;
        while (n_int && a < 100) begin
            @(negedge clk28);
            a++;
        end
        repeat (3) wait_ck(p);
        rst_n = 1'b0;
        @(negedge clk28);
        check("midrst_n_int", int'(n_int), 1);
        check("midrst_n_int_next", int'(n_int_next), 1);
        check("midrst_clkcpu", int'(clkcpu), 0);
        check("midrst_tstate", int'(tstate), 0);
        rst_n = 1'b1;
        repeat (2) wait_ck(p);
        trigger(9'd248);
        measure_int();
        check("postrst_low_cks", r_low_cks, 36);
        check("postrst_ts_first", r_ts_first, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
